// File: rtl/flow_pkg.sv
// Shared types and constants for the flowing-light control stage.
package flow_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } run_state_t;

  localparam int unsigned KEY_FASTER = 0;
  localparam int unsigned KEY_SLOWER = 1;
  localparam int unsigned KEY_PAUSE  = 2;
  localparam int unsigned NUM_KEYS   = 3;

  // Defaults for a 50 MHz clock: 20 ms debounce, 25 ms fastest step.
  localparam int unsigned DEB_CYC_DEF    = 1_000_000;
  localparam int unsigned MIN_PERIOD_DEF = 1_250_000;

  function automatic logic [31:0] step_period(input logic [31:0] min_period,
                                              input logic [4:0]  shift);
    return min_period << shift;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, stability counter, press pulse on 1->0.
module key_debounce
  import flow_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned    CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_stable) begin
        if (r_cnt == CNT_LAST) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
          // Pulse is high in the first cycle the stable state reads pressed.
          r_press  <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/flow_step_ctrl.sv
// Speed level, run/pause state and step-pulse generator for the LED flow stage.
module flow_step_ctrl
  import flow_pkg::*;
#(
  parameter  int unsigned DEB_CYC    = DEB_CYC_DEF,
  parameter  int unsigned MIN_PERIOD = MIN_PERIOD_DEF,
  parameter  int unsigned LEVELS     = 8,
  parameter  int unsigned LEVEL_RST  = 3,
  localparam int unsigned LW         = $clog2(LEVELS)
) (
  input  logic                clk_50M,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                step,
  output logic [LW-1:0]       level,
  output logic                running
);

  localparam logic [LW-1:0] LEVEL_MAX  = LW'(LEVELS - 1);
  localparam logic [LW-1:0] LEVEL_INIT = LW'(LEVEL_RST);

  logic [NUM_KEYS-1:0] w_press;
  logic                w_faster;
  logic                w_slower;
  logic                w_toggle;
  logic                w_level_up;
  logic                w_level_dn;
  logic                w_level_chg;
  logic [4:0]          w_shift;
  logic [31:0]         w_period;
  logic                w_wrap;

  run_state_t  r_state;
  run_state_t  w_state_nxt;
  logic [LW-1:0] r_level;
  logic [31:0]   r_tick;
  logic          r_step;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .i_clk   (clk_50M),
      .i_rst_n (reset_n),
      .i_key_n (key_n[gi]),
      .o_press (w_press[gi])
    );
  end

  always_comb begin
    w_faster    = w_press[KEY_FASTER];
    w_slower    = w_press[KEY_SLOWER];
    w_toggle    = w_press[KEY_PAUSE];
    w_level_up  = w_faster & ~w_slower & (r_level != LEVEL_MAX);
    w_level_dn  = w_slower & ~w_faster & (r_level != '0);
    w_level_chg = w_level_up | w_level_dn;
    w_shift     = 5'(LEVELS - 1) - 5'(r_level);
    w_period    = step_period(32'(MIN_PERIOD), w_shift);
    w_wrap      = (r_state == RUN) && (r_tick == w_period - 32'd1);
  end

  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_toggle) begin
      w_state_nxt = (r_state == RUN) ? PAUSE : RUN;
    end
  end

  // Tick and level decisions use the pre-toggle state, so a toggle on the
  // wrap cycle still emits its step.
  always_ff @(posedge clk_50M or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= LEVEL_INIT;
      r_tick  <= '0;
      r_step  <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (w_level_up) begin
        r_level <= r_level + 1'b1;
      end else if (w_level_dn) begin
        r_level <= r_level - 1'b1;
      end

      if (w_level_chg) begin
        r_tick <= '0;
      end else if (r_state == RUN) begin
        if (w_wrap) begin
          r_tick <= '0;
          r_step <= 1'b1;
        end else begin
          r_tick <= r_tick + 32'd1;
        end
      end
    end
  end

  assign step    = r_step;
  assign level   = r_level;
  assign running = (r_state == RUN);

endmodule

// File: tb/tb_flow_step_ctrl.sv
// Directed bench for flow_step_ctrl with small debounce and period parameters.
module tb_flow_step_ctrl;

  localparam int unsigned TB_DEB    = 4;
  localparam int unsigned TB_MINP   = 2;
  localparam int unsigned TB_LEVELS = 8;
  localparam int unsigned TB_LRST   = 3;
  localparam int unsigned TB_LW     = $clog2(TB_LEVELS);

  logic             clk_50M = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       key_n   = 3'b111;
  logic             step;
  logic [TB_LW-1:0] level;
  logic             running;

  int checks = 0;
  int errors = 0;

  always #5 clk_50M = ~clk_50M;

  initial begin
    assert ((64'(TB_MINP) << (TB_LEVELS - 1)) <= 64'hFFFF_FFFF)
      else $fatal(1, "FAIL period_range: slowest period exceeds 32 bits");
  end

  flow_step_ctrl #(
    .DEB_CYC    (TB_DEB),
    .MIN_PERIOD (TB_MINP),
    .LEVELS     (TB_LEVELS),
    .LEVEL_RST  (TB_LRST)
  ) dut (
    .clk_50M (clk_50M),
    .reset_n (reset_n),
    .key_n   (key_n),
    .step    (step),
    .level   (level),
    .running (running)
  );

  // Advance n rising edges, sampling 1 time unit after each; report step pulses.
  task automatic run_edges(input int n, output int first, output int nsteps);
    first  = 0;
    nsteps = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk_50M);
      #1;
      if (step === 1'b1) begin
        nsteps++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    key_n   = 3'b111;
    repeat (3) @(posedge clk_50M);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int f, n;
    do_reset();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL reset_level: got %0d want 3", level); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL reset_running: got %b want 1", running); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b want 0", step); end
    run_edges(31, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL first_period_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL first_step_edge32: got %0d steps want 1", n); end
    run_edges(31, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL second_period_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL second_step_edge64: got %0d steps want 1", n); end
  endtask

  // Faster press lands on the wrap edge (32): step must be suppressed.
  task automatic test_faster();
    int f, n;
    do_reset();
    run_edges(25, f, n);
    key_n[0] = 1'b0;
    run_edges(6, f, n);
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL faster_latency: got level %0d want 3", level); end
    run_edges(1, f, n);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL faster_level: got %0d want 4", level); end
    checks++; if (n != 0) begin errors++; $display("FAIL faster_suppress: got %0d steps want 0", n); end
    run_edges(3, f, n);
    key_n[0] = 1'b1;
    run_edges(12, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL faster_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL faster_period16: got %0d steps want 1", n); end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL faster_hold: got level %0d want 4", level); end
  endtask

  task automatic test_slower_saturate();
    int f, n, total;
    logic [TB_LW-1:0] exp_lv [5];
    exp_lv = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    total = 0;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      key_n[1] = 1'b0;
      run_edges(10, f, n);
      total += n;
      checks++; if (level !== exp_lv[p]) begin errors++; $display("FAIL slower_press%0d: got level %0d want %0d", p, level, exp_lv[p]); end
      key_n[1] = 1'b1;
      run_edges(10, f, n);
      total += n;
    end
    checks++; if (total != 0) begin errors++; $display("FAIL slower_quiet: got %0d steps want 0", total); end
    // Last real change was at edge 47; saturated presses must not restart the count.
    run_edges(202, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL slower_period256_early: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL slower_step_edge303: got %0d steps want 1", n); end
  endtask

  task automatic test_glitch();
    int f, n;
    do_reset();
    run_edges(5, f, n);
    key_n[0] = 1'b0;
    run_edges(3, f, n);
    key_n[0] = 1'b1;
    run_edges(23, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL glitch_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL glitch_cadence: got %0d steps want 1", n); end
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL glitch_level: got %0d want 3", level); end
  endtask

  task automatic test_pause();
    int f, n;
    do_reset();
    run_edges(4, f, n);
    key_n[2] = 1'b0;
    run_edges(6, f, n);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_latency: got running %b want 1", running); end
    run_edges(1, f, n);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_enter: got running %b want 0", running); end
    run_edges(3, f, n);
    key_n[2] = 1'b1;
    run_edges(100, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL pause_no_steps: got %0d steps want 0", n); end
    key_n[2] = 1'b0;
    run_edges(6, f, n);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL resume_latency: got running %b want 0", running); end
    run_edges(1, f, n);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume: got running %b want 1", running); end
    run_edges(3, f, n);
    key_n[2] = 1'b1;
    run_edges(17, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL resume_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL resume_step21: got %0d steps want 1", n); end
  endtask

  task automatic test_toggle_at_wrap();
    int f, n;
    do_reset();
    run_edges(25, f, n);
    key_n[2] = 1'b0;
    run_edges(6, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL twrap_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL twrap_step: got %0d steps want 1", n); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL twrap_pause: got running %b want 0", running); end
    run_edges(3, f, n);
    key_n[2] = 1'b1;
    run_edges(20, f, n);
    key_n[2] = 1'b0;
    run_edges(7, f, n);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL twrap_resume: got running %b want 1", running); end
    run_edges(3, f, n);
    key_n[2] = 1'b1;
    run_edges(28, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL twrap_wrapped_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL twrap_full_period: got %0d steps want 1", n); end
  endtask

  task automatic test_reset_mid();
    int f, n;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      key_n[0] = 1'b0;
      run_edges(10, f, n);
      key_n[0] = 1'b1;
      run_edges(10, f, n);
    end
    checks++; if (level !== 3'd5) begin errors++; $display("FAIL mid_level5: got %0d want 5", level); end
    key_n[2] = 1'b0;
    run_edges(10, f, n);
    key_n[2] = 1'b1;
    run_edges(10, f, n);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL mid_paused: got running %b want 0", running); end
    reset_n = 1'b0;
    #1;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_async_level: got %0d want 3", level); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL mid_async_running: got %b want 1", running); end
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL mid_async_step: got %b want 0", step); end
    repeat (3) @(posedge clk_50M);
    #1;
    reset_n = 1'b1;
    run_edges(31, f, n);
    checks++; if (n != 0) begin errors++; $display("FAIL mid_release_quiet: got %0d steps want 0", n); end
    run_edges(1, f, n);
    checks++; if (n != 1) begin errors++; $display("FAIL mid_release_step32: got %0d steps want 1", n); end
    // Step is high now; asynchronous reset must drop it without a clock edge.
    reset_n = 1'b0;
    #1;
    checks++; if (step !== 1'b0) begin errors++; $display("FAIL mid_async_step_drop: got %b want 0", step); end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_faster();
    test_slower_saturate();
    test_glitch();
    test_pause();
    test_toggle_at_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
